regfile_checker: RTL
====================

Name: regfile_checker

Overview:
- Synthesizable run-and-check engine that replaces the simulation-only register-dump harness, so the same check can run on FPGA.
- Holds the processor in reset, releases it for a programmed number of cycles, then takes over regfile read port A and compares every register against an expected-value ROM.
- Counts nonzero-destination writebacks during the run and reports pass/fail, error count and the first mismatch.

Parameters:
- DATA_WIDTH, 32, register and expected-value width
- NUM_REGS, 32, number of registers scanned (index 0..NUM_REGS-1)
- REG_ADDR_W, 5, register index width; NUM_REGS <= 2**REG_ADDR_W
- CYCLE_W, 16, width of run-cycle and writeback counters
- STOP_ON_FAIL, 0, 1 = end the scan at the first mismatch; 0 = scan all registers

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run, sampled only in IDLE
- num_cycles  in  CYCLE_W  run length, latched on start
- cpu_reset  out  1  active-high reset driven to processor and regfile
- test_mode  out  1  high while scanning; muxes test_reg_addr onto regfile read port A
- test_reg_addr  out  REG_ADDR_W  register index under test
- reg_data  in  DATA_WIDTH  regfile port A data (combinational read)
- exp_addr  out  REG_ADDR_W  expected-ROM address
- exp_data  in  DATA_WIDTH  expected-ROM data, 1-cycle synchronous read
- wb_en  in  1  processor regfile write enable
- wb_reg  in  REG_ADDR_W  processor write destination
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- pass  out  1  valid with done; high when err_count == 0
- err_count  out  REG_ADDR_W+1  mismatches found
- fail_reg  out  REG_ADDR_W  index of first mismatch
- fail_exp  out  DATA_WIDTH  expected value at first mismatch
- fail_act  out  DATA_WIDTH  actual value at first mismatch
- wb_count  out  CYCLE_W  writebacks with wb_reg != 0 during RUN; saturates at all-ones

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - cpu_reset=1, test_mode=0, busy=0, done=0, pass=0.
  - All counters, addresses and fail_* fields are 0.
- IDLE: cpu_reset=1. On start, latch num_cycles, clear err_count, wb_count and fail_*, then go to CPU_RST.
- CPU_RST: one cycle with cpu_reset=1. Next state is RUN, or SCAN_ISSUE if the latched count is 0.
- RUN: cpu_reset=0 for exactly num_cycles cycles.
  - Each cycle with wb_en=1 and wb_reg != 0 increments wb_count.
  - When the run counter reaches num_cycles-1, go to SCAN_ISSUE with index 0.
- SCAN_ISSUE:
  - cpu_reset=1, which freezes the processor, so wb_* is ignored.
  - test_mode=1; test_reg_addr and exp_addr = index.
  - Go to SCAN_CMP.
- SCAN_CMP: addresses are held. Compare reg_data to exp_data over the full width (register 0 included).
  - On mismatch: increment err_count. If this is the first mismatch, capture fail_reg, fail_exp and fail_act.
  - If mismatch and STOP_ON_FAIL=1, go to DONE.
  - Otherwise, if index == NUM_REGS-1, go to DONE; else increment index and go to SCAN_ISSUE.
  - Cost is 2 cycles per register.
- DONE: done=1, pass=(err_count==0), test_mode=0, cpu_reset=1; all results held. start returns to CPU_RST with results cleared.
- Latency from the start edge to done = 1 + num_cycles + 2*NUM_REGS cycles (full scan).
- start is ignored while busy.
- Reset asserted mid-run or mid-scan aborts immediately to IDLE with reset values.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, CPU_RST, RUN, SCAN_ISSUE, SCAN_CMP, DONE)
  - the default DATA_WIDTH, NUM_REGS and CYCLE_W constants
- One sub-module: checker_scoreboard. It holds err_count, first-fail capture and the pass flag, with clear, cmp_valid, reg_idx, exp and act inputs.
- The FSM, run counter and wb counter stay in the top level.

Test Plan:
- num_cycles=10, ROM matches regfile, 3 writes to r5/r6/r7 plus 1 write to r0 -> done at cycle 1+10+64=75, pass=1, err_count=0, wb_count=3.
- Expected r4=7, actual r4=9, STOP_ON_FAIL=0 -> err_count=1, fail_reg=4, fail_exp=7, fail_act=9, pass=0, done at the full-scan latency.
- Mismatches at r2 and r9, STOP_ON_FAIL=1 -> done 1+N+6 cycles after start, err_count=1, fail_reg=2.
- num_cycles=0 -> cpu_reset never deasserts, scan starts directly, done after 1+64 cycles, wb_count=0.
- reset=0 at run cycle 5 of 10 -> same cycle: busy=0, cpu_reset=1, err_count=0. A subsequent start runs a clean full sequence.
- start pulsed during RUN and SCAN -> ignored and latched num_cycles unchanged. start in DONE -> new run with cleared results.

Source files
------------

// File: rtl/regfile_checker_pkg.sv
// Shared types and default sizing for the regfile run-and-check engine.
package regfile_checker_pkg;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS   = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_CYCLE_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    CPU_RST,
    RUN,
    SCAN_ISSUE,
    SCAN_CMP,
    DONE
  } state_t;
endpackage

// File: rtl/checker_scoreboard.sv
// Mismatch counter and first-failure capture for the register scan.
module checker_scoreboard
  import regfile_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_cmp_valid,
  input  logic                  i_done,
  input  logic [REG_ADDR_W-1:0] i_reg_idx,
  input  logic [DATA_WIDTH-1:0] i_exp,
  input  logic [DATA_WIDTH-1:0] i_act,
  output logic                  o_mismatch,
  output logic                  o_pass,
  output logic [REG_ADDR_W:0]   o_err_count,
  output logic [REG_ADDR_W-1:0] o_fail_reg,
  output logic [DATA_WIDTH-1:0] o_fail_exp,
  output logic [DATA_WIDTH-1:0] o_fail_act
);
  localparam logic [REG_ADDR_W:0] ERR_ONE = 1;

  logic                  w_mismatch;
  logic [REG_ADDR_W:0]   r_err_count;
  logic [REG_ADDR_W-1:0] r_fail_reg;
  logic [DATA_WIDTH-1:0] r_fail_exp;
  logic [DATA_WIDTH-1:0] r_fail_act;

  assign w_mismatch = i_cmp_valid && (i_exp != i_act);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_count <= '0;
      r_fail_reg  <= '0;
      r_fail_exp  <= '0;
      r_fail_act  <= '0;
    end else if (i_clear) begin
      r_err_count <= '0;
      r_fail_reg  <= '0;
      r_fail_exp  <= '0;
      r_fail_act  <= '0;
    end else if (w_mismatch) begin
      r_err_count <= r_err_count + ERR_ONE;
      // Only the first mismatch of a run is recorded.
      if (r_err_count == '0) begin
        r_fail_reg <= i_reg_idx;
        r_fail_exp <= i_exp;
        r_fail_act <= i_act;
      end
    end
  end

  assign o_mismatch  = w_mismatch;
  assign o_pass      = i_done && (r_err_count == '0);
  assign o_err_count = r_err_count;
  assign o_fail_reg  = r_fail_reg;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_act  = r_fail_act;
endmodule

// File: rtl/regfile_checker.sv
// Run-and-check engine: resets the CPU, runs it for a programmed number of
// cycles, then scans the register file against an expected-value ROM.
module regfile_checker
  import regfile_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
  parameter int unsigned REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int unsigned CYCLE_W      = DEF_CYCLE_W,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    num_cycles,
  output logic                  cpu_reset,
  output logic                  test_mode,
  output logic [REG_ADDR_W-1:0] test_reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [REG_ADDR_W:0]   err_count,
  output logic [REG_ADDR_W-1:0] fail_reg,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [CYCLE_W-1:0]    wb_count
);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [REG_ADDR_W-1:0] IDX_ONE  = 1;
  localparam logic [CYCLE_W-1:0]    CNT_ONE  = 1;

  state_t                r_state;
  state_t                w_next;
  logic [CYCLE_W-1:0]    r_num_cycles;
  logic [CYCLE_W-1:0]    r_run_cnt;
  logic [CYCLE_W-1:0]    r_wb_count;
  logic [REG_ADDR_W-1:0] r_idx;
  logic                  w_start_ok;
  logic                  w_mismatch;
  logic                  w_cmp_valid;

  assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
  assign w_cmp_valid = (r_state == SCAN_CMP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cpu_reset = 1'b1;
    test_mode = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = CPU_RST;
      end
      CPU_RST: w_next = (r_num_cycles == '0) ? SCAN_ISSUE : RUN;
      RUN: begin
        cpu_reset = 1'b0;
        if (r_run_cnt == r_num_cycles - CNT_ONE) w_next = SCAN_ISSUE;
      end
      SCAN_ISSUE: begin
        test_mode = 1'b1;
        w_next    = SCAN_CMP;
      end
      SCAN_CMP: begin
        test_mode = 1'b1;
        if ((w_mismatch && STOP_ON_FAIL) || r_idx == LAST_IDX) w_next = DONE;
        else                                                   w_next = SCAN_ISSUE;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) w_next = CPU_RST;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_num_cycles <= '0;
      r_run_cnt    <= '0;
      r_wb_count   <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_num_cycles <= num_cycles;
            r_run_cnt    <= '0;
            r_wb_count   <= '0;
            r_idx        <= '0;
          end
        end
        RUN: begin
          r_run_cnt <= r_run_cnt + CNT_ONE;
          if (wb_en && wb_reg != '0 && r_wb_count != '1)
            r_wb_count <= r_wb_count + CNT_ONE;
        end
        SCAN_CMP: begin
          if (w_next == SCAN_ISSUE) r_idx <= r_idx + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  checker_scoreboard #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_scoreboard (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_clear    (w_start_ok),
    .i_cmp_valid(w_cmp_valid),
    .i_done     (done),
    .i_reg_idx  (r_idx),
    .i_exp      (exp_data),
    .i_act      (reg_data),
    .o_mismatch (w_mismatch),
    .o_pass     (pass),
    .o_err_count(err_count),
    .o_fail_reg (fail_reg),
    .o_fail_exp (fail_exp),
    .o_fail_act (fail_act)
  );

  assign test_reg_addr = r_idx;
  assign exp_addr      = r_idx;
  assign wb_count      = r_wb_count;
endmodule
